uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_if.sv | 24 ++
 rtl/uart_rx_fifo.sv | 49 ++++
 tb/tb_uart_rx_fifo.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive-side write/read handshake, occupancy and overflow signals (slave = FIFO, master = user)
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
);
  logic [DATA_WIDTH-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic out_valid;
  logic out_ready;
  logic [$clog2(DEPTH):0] count;
  logic almost_full;
  logic overflow;
  logic clr_ovf;
  modport slave (
    input in_data, in_valid, out_ready, clr_ovf,
    output in_ready, out_data, out_valid, count, almost_full, overflow
  );
  modport master (
    output in_data, in_valid, out_ready, clr_ovf,
    input in_ready, out_data, out_valid, count, almost_full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT FIFO for UART words; clk/rst plus bus (in_* write, out_* read, count, almost_full, sticky overflow, clr_ovf)
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AFULL_LEVEL = 12
) (
  input logic clk,
  input logic rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic overflow_q, overflow_d;
  logic full, wr, rd;
  always_comb begin
    full = count_q == CW'(DEPTH);
    wr = bus.in_valid && !full;
    rd = bus.out_ready && count_q != '0;
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = (wr && !rd) ? count_q + CW'(1) : (rd && !wr) ? count_q - CW'(1) : count_q;
    overflow_d = (bus.in_valid && full) ? 1'b1 : bus.clr_ovf ? 1'b0 : overflow_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr && !rst) mem_q[wr_ptr_q] <= bus.in_data;
  end
  assign bus.in_ready = !full;
  assign bus.out_valid = count_q != '0;
  assign bus.out_data = mem_q[rd_ptr_q];
  assign bus.count = count_q;
  assign bus.almost_full = count_q >= CW'(AFULL_LEVEL);
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and queue-referenced checks of uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk = 0;
  logic rst = 1;
  int passed = 0;
  int total = 0;
  uart_rx_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus();
  uart_rx_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(12)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 0;
    bus.out_ready = 0;
    bus.clr_ovf = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1;
      bus.in_data = base + 8'(i);
      step();
    end
    bus.in_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    bus.in_data = 0;
    do_reset();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", bus.in_ready); else passed++;
    total++; if (bus.count !== 5'd0) $display("FAIL reset_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.almost_full !== 1'b0) $display("FAIL reset_afull got %0b want 0", bus.almost_full); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %0b want 0", bus.overflow); else passed++;
  endtask

  task automatic test_single();
    fill(8'hA5, 1);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL single_valid got %0b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 8'hA5) $display("FAIL single_data got %0h want a5", bus.out_data); else passed++;
    total++; if (bus.count !== 5'd1) $display("FAIL single_count got %0d want 1", bus.count); else passed++;
    bus.out_ready = 1;
    step();
    bus.out_ready = 0;
    total++; if (bus.count !== 5'd0) $display("FAIL single_pop_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL single_pop_valid got %0b want 0", bus.out_valid); else passed++;
  endtask

  task automatic test_fill_wrap(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.almost_full !== (i >= 12)) $display("FAIL fill_afull at count %0d got %0b want %0b", i, bus.almost_full, i >= 12); else passed++;
      bus.in_valid = 1;
      bus.in_data = base + 8'(i);
      step();
    end
    bus.in_valid = 0;
    total++; if (bus.count !== 5'd16) $display("FAIL fill_count got %0d want 16", bus.count); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL fill_in_ready got %0b want 0", bus.in_ready); else passed++;
    total++; if (bus.almost_full !== 1'b1) $display("FAIL fill_afull_full got %0b want 1", bus.almost_full); else passed++;
    bus.out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      total++; if (bus.out_data !== base + 8'(i)) $display("FAIL drain_data[%0d] got %0h want %0h", i, bus.out_data, base + 8'(i)); else passed++;
      step();
    end
    bus.out_ready = 0;
    total++; if (bus.count !== 5'd0) $display("FAIL drain_count got %0d want 0", bus.count); else passed++;
  endtask

  task automatic test_full_read();
    do_reset();
    fill(8'h20, 16);
    bus.in_valid = 1;
    bus.in_data = 8'h55;
    bus.out_ready = 1;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL fullrd_in_ready got %0b want 0", bus.in_ready); else passed++;
    step();
    bus.out_ready = 0;
    total++; if (bus.count !== 5'd15) $display("FAIL fullrd_count got %0d want 15", bus.count); else passed++;
    total++; if (bus.overflow !== 1'b1) $display("FAIL fullrd_ovf got %0b want 1", bus.overflow); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL fullrd_in_ready_next got %0b want 1", bus.in_ready); else passed++;
    step();
    bus.in_valid = 0;
    total++; if (bus.count !== 5'd16) $display("FAIL fullrd_refill_count got %0d want 16", bus.count); else passed++;
    bus.out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] e;
      e = (i == 15) ? 8'h55 : 8'h21 + 8'(i);
      total++; if (bus.out_data !== e) $display("FAIL fullrd_drain[%0d] got %0h want %0h", i, bus.out_data, e); else passed++;
      step();
    end
    bus.out_ready = 0;
  endtask

  task automatic test_ovf_clear();
    bus.clr_ovf = 1;
    step();
    bus.clr_ovf = 0;
    total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear got %0b want 0", bus.overflow); else passed++;
    fill(8'h40, 16);
    total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_not_set_yet got %0b want 0", bus.overflow); else passed++;
    bus.in_valid = 1;
    step();
    total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", bus.overflow); else passed++;
    bus.clr_ovf = 1;
    step();
    total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set_and_clear got %0b want 1", bus.overflow); else passed++;
    bus.in_valid = 0;
    step();
    bus.clr_ovf = 0;
    total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clear_again got %0b want 0", bus.overflow); else passed++;
  endtask

  task automatic test_simul();
    logic [7:0] q[$];
    logic wr, rd;
    do_reset();
    fill(8'h60, 1);
    bus.in_valid = 1;
    bus.out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      total++; if (bus.out_data !== 8'h60 + 8'(i)) $display("FAIL simul1_data[%0d] got %0h want %0h", i, bus.out_data, 8'h60 + 8'(i)); else passed++;
      bus.in_data = 8'h61 + 8'(i);
      step();
      total++; if (bus.count !== 5'd1 || bus.out_valid !== 1'b1) $display("FAIL simul1_count got %0d/%0b want 1/1", bus.count, bus.out_valid); else passed++;
    end
    idle();
    fill(8'h70, 7);
    bus.in_valid = 1;
    bus.out_ready = 1;
    bus.in_data = 8'h7F;
    step();
    idle();
    total++; if (bus.count !== 5'd8) $display("FAIL simul8_count got %0d want 8", bus.count); else passed++;
    total++; if (bus.out_data !== 8'h70) $display("FAIL simul8_head got %0h want 70", bus.out_data); else passed++;
    q = {8'h70, 8'h71, 8'h72, 8'h73, 8'h74, 8'h75, 8'h76, 8'h7F};
    for (int c = 0; c < 1000; c++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_data = 8'($urandom_range(0, 255));
      #1;
      total++; if (bus.count !== 5'(q.size())) $display("FAIL rand_count c%0d got %0d want %0d", c, bus.count, q.size()); else passed++;
      total++; if (bus.in_ready !== (q.size() < 16)) $display("FAIL rand_in_ready c%0d got %0b want %0b", c, bus.in_ready, q.size() < 16); else passed++;
      if (q.size() != 0) begin
        total++; if (bus.out_data !== q[0]) $display("FAIL rand_data c%0d got %0h want %0h", c, bus.out_data, q[0]); else passed++;
      end
      wr = bus.in_valid && q.size() < 16;
      rd = bus.out_ready && q.size() > 0;
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(bus.in_data);
      step();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill(8'h90, 5);
    total++; if (bus.count !== 5'd5) $display("FAIL mid_pre_count got %0d want 5", bus.count); else passed++;
    rst = 1;
    bus.in_valid = 1;
    bus.out_ready = 1;
    step();
    rst = 0;
    idle();
    total++; if (bus.count !== 5'd0) $display("FAIL mid_count got %0d want 0", bus.count); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid got %0b want 0", bus.out_valid); else passed++;
    total++; if (bus.overflow !== 1'b0) $display("FAIL mid_ovf got %0b want 0", bus.overflow); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL mid_in_ready got %0b want 1", bus.in_ready); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_wrap(8'h00);
    test_fill_wrap(8'h10);
    test_full_read();
    test_ovf_clear();
    test_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
